div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Unsigned restoring divider, one quotient bit per clock.
// A division is accepted from IDLE, iterates WIDTH times in BUSY, passes
// through DONE, and the done pulse is registered out of the DONE state so
// it is seen in the cycle that follows it. A new start may be presented in
// that same cycle, which keeps back-to-back divisions WIDTH+2 cycles apart.
// Divide-by-zero skips the iteration and reports all-ones / dividend / dbz.
//
// Handshake: start is sampled on a rising edge only while ready=1. That
// edge captures A and B. Q, R and dbz are valid while done=1 and hold
// their values until the next completion.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic             r_done;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_last;
    logic             w_accept;

    // One restoring step. The trial subtract is WIDTH+1 bits so that the
    // bit shifted out of the remainder still takes part in the compare
    // when the divisor is 2^(WIDTH-1) or larger.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_sub     = w_shift - {1'b0, r_div};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_accept  = (r_state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: zero divisor goes straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (B == '0) ? DONE : BUSY;
            BUSY:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working registers, iteration counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= A;
            r_div <= B;
            if (B == '0) begin
                r_q   <= '1;
                r_r   <= A;
                r_dbz <= 1'b1;
            end
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CW'(1);
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (w_last) begin
                r_q   <= w_quo_nxt;
                r_r   <= w_rem_nxt;
                r_dbz <= 1'b0;
            end
        end
    end

    // Done pulse follows the single DONE cycle; reset drops it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= (r_state == DONE);
    end

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign Q     = r_q;
    assign R     = r_r;
    assign dbz   = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random operands, all
// checked against plain integer division.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         ready;
  logic         done;
  logic [W-1:0] q_out;
  logic [W-1:0] r_out;
  logic         dbz;

  int n_vec;
  int n_err;

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .ready (ready),
    .done  (done),
    .Q     (q_out),
    .R     (r_out),
    .dbz   (dbz)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = {W{1'b1}};
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // present operands and start; returns #1 after the accepting edge
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // wait for done, check latency and results; returns #1 after the done edge
  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit scramble);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           n;
    bit           got;
    model(a, b, eq, er, ez);
    n   = 0;
    got = 0;
    while (n < 100 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1;
      else if (scramble) begin
        a_in  = $urandom;
        b_in  = $urandom;
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    if (!got) begin
      check({tag, "_timeout"}, 64'(got), 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(n), (b == 0) ? 64'd1 : 64'(W + 1));
      check({tag, "_q"}, 64'(q_out), 64'(eq));
      check({tag, "_r"}, 64'(r_out), 64'(er));
      check({tag, "_dbz"}, 64'(dbz), 64'(ez));
    end
  endtask

  // one isolated division followed by a check that done was one cycle wide
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scramble);
    launch(a, b);
    wait_result(tag, a, b, scramble);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           saw_done;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // reset, then hold idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_low", 64'(ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_done", 64'(done), 64'd0);
    check("idle_q", 64'(q_out), 64'd0);
    check("idle_r", 64'(r_out), 64'd0);
    check("idle_dbz", 64'(dbz), 64'd0);

    // directed cases
    run_div("d10_5", 32'h0000_000A, 32'h0000_0005, 1'b0);
    run_div("wide", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_div("dbz", 32'h0000_0007, 32'h0000_0000, 1'b0);
    check("hold_q", 64'(q_out), 64'hFFFF_FFFF);
    run_div("max_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_div("lt", 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);

    // noisy inputs during BUSY, then immediate back-to-back start
    launch(32'd100, 32'd7);
    wait_result("noisy", 32'd100, 32'd7, 1'b1);
    a_in  = 32'd1000;
    b_in  = 32'd33;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_accept", 64'(ready), 64'd0);
    wait_result("b2b", 32'd1000, 32'd33, 1'b0);
    @(posedge clk);
    #1;

    // random operands, a mix of divisor magnitudes and zero
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 255));
        1:       rb = $urandom;
        2:       rb = 32'h8000_0000 | $urandom;
        default: rb = (i % 2 == 0) ? 32'd0 : 32'($urandom_range(1, 16));
      endcase
      run_div($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    // reset during BUSY aborts with no done pulse
    launch(32'hDEAD_BEEF, 32'd13);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(q_out), 64'd0);
    check("abort_r", 64'(r_out), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);

    // fresh division on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    a_in  = 32'd9;
    b_in  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("post_rst_accept", 64'(ready), 64'd0);
    wait_result("post_rst", 32'd9, 32'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
